imem_loader: RTL and testbench

- Sequences bulk loading of the 64 x 16-bit instruction memory from an 8-bit byte stream, e.g. a debug UART receiver.
- Drives write port 1 of the instruction memory.
- Holds the pipeline in stall while a load is in progress.
- Assembles bytes into 16-bit words, low byte first, and writes them to consecutive addresses with wrap-around. Reports completion and a running 16-bit checksum.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and loader FSM encoding for the instruction memory subsystem.
// The instruction memory and pipeline import the same sizes.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 6;
    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_DATA_W = 16;
    localparam int BYTE_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } load_state_e;

endpackage

// File: rtl/imem_loader.sv
// Bulk loader for the instruction memory: packs a byte stream into 16-bit words,
// writes them through memory port 1 and stalls the core while a load runs.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_count,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] instruction_wr1,
    output logic [DATA_W-1:0] instruction_wr1_data,
    output logic              instruction_wr1_enable,
    output logic              core_stall,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error,
    output logic [DATA_W-1:0] load_checksum
);

    localparam int CNT_W = ADDR_W + 1;

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [BYTE_W-1:0] low_q, low_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic [CNT_W-1:0]  start_count;

    assign xfer = byte_valid && ready_q;

    // Any count with the top bit set means a full-memory load.
    assign start_count = load_count[ADDR_W] ? CNT_W'(DEPTH) : load_count;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        low_d       = low_q;
        checksum_d  = checksum_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        error_d     = load_start && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    addr_d      = load_base;
                    remaining_d = start_count;
                    checksum_d  = '0;
                    state_d     = (start_count == '0) ? ST_DONE : ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
                    low_d   = byte_in;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (xfer) begin
                    wr_data_d = {byte_in, low_q};
                    wr_addr_d = addr_q;
                    state_d   = ST_WR;
                end
            end
            ST_WR: begin
                checksum_d  = checksum_q + wr_data_q;
                addr_d      = addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                state_d     = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_LO;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered alongside it.
        ready_d = (state_d == ST_LO) || (state_d == ST_HI);
        busy_d  = (state_d == ST_LO) || (state_d == ST_HI) || (state_d == ST_WR);
        wr_en_d = (state_d == ST_WR);
        done_d  = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            low_q       <= '0;
            checksum_q  <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            low_q       <= low_d;
            checksum_q  <= checksum_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign byte_ready             = ready_q;
    assign instruction_wr1        = wr_addr_q;
    assign instruction_wr1_data   = wr_data_q;
    assign instruction_wr1_enable = wr_en_q;
    assign core_stall             = busy_q;
    assign load_busy              = busy_q;
    assign load_done              = done_q;
    assign load_error             = error_q;
    assign load_checksum          = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads push expected writes and
// completions; a negedge monitor pops and compares whatever the loader emits.
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        load_start;
    logic [5:0]  load_base;
    logic [6:0]  load_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [5:0]  instruction_wr1;
    logic [15:0] instruction_wr1_data;
    logic        instruction_wr1_enable;
    logic        core_stall;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [15:0] load_checksum;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] sum;
        logic        after_strobe;
    } done_t;

    wr_t   wr_exp[$];
    done_t done_exp[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit stall_window = 0;
    logic prev_wr = 1'b0;

    imem_loader dut (
        .clock                  (clock),
        .reset                  (reset),
        .load_start             (load_start),
        .load_base              (load_base),
        .load_count             (load_count),
        .byte_in                (byte_in),
        .byte_valid             (byte_valid),
        .byte_ready             (byte_ready),
        .instruction_wr1        (instruction_wr1),
        .instruction_wr1_data   (instruction_wr1_data),
        .instruction_wr1_enable (instruction_wr1_enable),
        .core_stall             (core_stall),
        .load_busy              (load_busy),
        .load_done              (load_done),
        .load_error             (load_error),
        .load_checksum          (load_checksum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe and every completion must match the head of its queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (instruction_wr1_enable) begin
                check("write_expected", 32'(wr_exp.size() != 0), 32'd1);
                if (wr_exp.size() != 0) begin
                    wr_t w;
                    w = wr_exp.pop_front();
                    check("write_addr", 32'(instruction_wr1), 32'(w.addr));
                    check("write_data", 32'(instruction_wr1_data), 32'(w.data));
                end
                check("ready_low_in_wr", 32'(byte_ready), 32'd0);
            end
            if (load_done) begin
                check("done_expected", 32'(done_exp.size() != 0), 32'd1);
                if (done_exp.size() != 0) begin
                    done_t d;
                    d = done_exp.pop_front();
                    check("done_checksum", 32'(load_checksum), 32'(d.sum));
                    check("done_after_strobe", 32'(prev_wr), 32'(d.after_strobe));
                end
                check("busy_low_at_done", 32'(load_busy), 32'd0);
            end
            if (stall_window) check("stall_held", 32'(core_stall), 32'd1);
            prev_wr = instruction_wr1_enable;
        end
    end

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_load(input logic [5:0] base, input logic [6:0] count,
                              input bit push_done, input logic [15:0] sum, input bit after_strobe);
        done_t d;
        if (push_done) begin
            d.sum = sum;
            d.after_strobe = after_strobe;
            done_exp.push_back(d);
        end
        load_base  = base;
        load_count = count;
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clock);
        byte_in    = b;
        byte_valid = 1'b1;
        tries      = 0;
        while (!byte_ready && tries < 40) begin
            @(negedge clock);
            tries++;
        end
        check("byte_accept", 32'(byte_ready), 32'd1);
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [5:0] addr, input logic [15:0] data, input int gap);
        wr_t w;
        w.addr = addr;
        w.data = data;
        wr_exp.push_back(w);
        send_byte(data[7:0], gap);
        send_byte(data[15:8], gap);
    endtask

    logic [15:0] words4 [4] = '{16'hA55A, 16'h0F0F, 16'hFFFF, 16'h8001};

    initial begin
        logic [15:0] sum;
        logic [15:0] wd;

        reset      = 1'b0;
        load_start = 1'b0;
        load_base  = '0;
        load_count = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("reset_outputs",
              {15'd0, byte_ready, instruction_wr1, instruction_wr1_enable, core_stall,
               load_busy, load_done, load_error, 1'b0, 5'd0},
              32'd0);
        check("reset_data_sum", {instruction_wr1_data, load_checksum}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Basic load: 0x1234@0, 0x5678@1.
        start_load(6'd0, 7'd2, 1, 16'h68AC, 1);
        check("ready_after_start", 32'(byte_ready), 32'd1);
        check("stall_after_start", 32'(core_stall), 32'd1);
        send_word(6'd0, 16'h1234, 0);
        send_word(6'd1, 16'h5678, 0);
        repeat (4) @(negedge clock);
        check("checksum_holds", 32'(load_checksum), 32'h68AC);
        check("idle_busy", 32'(load_busy), 32'd0);

        // Wrap-around: 62, 63, 0.
        start_load(6'd62, 7'd3, 1, 16'h0006, 1);
        send_word(6'd62, 16'h0001, 0);
        send_word(6'd63, 16'h0002, 0);
        send_word(6'd0,  16'h0003, 0);
        repeat (3) @(negedge clock);

        // Zero count, then a start during the DONE cycle is rejected.
        start_load(6'd7, 7'd0, 1, 16'h0000, 0);
        check("zero_done_pulse", 32'(load_done), 32'd1);
        check("zero_busy", 32'(load_busy), 32'd0);
        check("zero_checksum", 32'(load_checksum), 32'd0);
        load_base  = 6'd9;
        load_count = 7'd1;
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
        check("done_start_error", 32'(load_error), 32'd1);
        check("done_start_no_busy", 32'(load_busy), 32'd0);
        check("done_start_no_ready", 32'(byte_ready), 32'd0);
        check("zero_done_once", 32'(load_done), 32'd0);
        repeat (3) @(negedge clock);

        // Back-pressure with random gaps; stall must stay high throughout.
        sum = 16'h3469;
        start_load(6'd20, 7'd4, 1, sum, 1);
        stall_window = 1;
        for (int i = 0; i < 4; i++) send_word(6'(20 + i), words4[i], int'($urandom_range(0, 3)));
        stall_window = 0;
        repeat (3) @(negedge clock);

        // Rejected start while in LO; original load must finish unchanged.
        start_load(6'd40, 7'd2, 1, 16'h89ED, 1);
        load_base  = 6'd3;
        load_count = 7'd5;
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
        check("lo_start_error", 32'(load_error), 32'd1);
        check("lo_still_ready", 32'(byte_ready), 32'd1);
        @(negedge clock);
        check("error_one_cycle", 32'(load_error), 32'd0);
        send_word(6'd40, 16'hBEEF, 0);
        send_word(6'd41, 16'hCAFE, 1);
        repeat (3) @(negedge clock);

        // Full 64-word load from base 48: every address once, wrapping past 63.
        sum = '0;
        for (int i = 0; i < 64; i++) sum = sum + {8'(i ^ 8'h5A), 8'(i)};
        start_load(6'd48, 7'h40, 1, sum, 1);
        for (int i = 0; i < 64; i++) begin
            wd = {8'(i ^ 8'h5A), 8'(i)};
            send_word(6'(48 + i), wd, 0);
        end
        repeat (3) @(negedge clock);

        // Reset after the low byte of the first word: abort with no late strobe.
        start_load(6'd10, 7'd2, 0, 16'h0000, 0);
        send_byte(8'h11, 0);
        reset = 1'b1;
        #1;
        check("abort_outputs",
              {16'd0, byte_ready, instruction_wr1_enable, core_stall, load_busy,
               load_done, load_error, instruction_wr1, 4'd0},
              32'd0);
        check("abort_data_sum", {instruction_wr1_data, load_checksum}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("abort_idle", {30'd0, load_busy, byte_ready}, 32'd0);

        start_load(6'd5, 7'd1, 1, 16'hABCD, 1);
        send_word(6'd5, 16'hABCD, 0);
        repeat (4) @(negedge clock);

        check("writes_drained", 32'(wr_exp.size()), 32'd0);
        check("dones_drained", 32'(done_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
